stopwatch_ctrl: RTL and testbench

Control FSM for the stopwatch. Consumes the four debounced button/switch levels (rst, pause, sel, adj) and the divided timing ticks. Issues clear and increment commands to the minute/second counter datapath and blink enables to the display driver. Sits between the debouncer and the counter/display blocks.

---
 rtl/stopwatch_ctrl.sv | 126 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced buttons and divided ticks into
// clear/increment commands for the counter datapath and blink enables for the display.
module stopwatch_ctrl #(
  parameter int BLINK_TICKS   = 1,
  parameter int SEL_SEC_VALUE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_rst,
  input  logic btn_pause,
  input  logic sel,
  input  logic adj,
  input  logic tick_1hz,
  input  logic tick_2hz,
  input  logic sec_at_max,
  output logic clr,
  output logic sec_inc,
  output logic min_inc,
  output logic running,
  output logic adj_mode,
  output logic blink_sec,
  output logic blink_min
);

  // state  | meaning
  // S_RUN    | counting seconds on tick_1hz
  // S_PAUSED | frozen, ticks discarded
  // S_ADJ    | manual field adjust on tick_2hz, selected field blinks
  typedef enum logic [1:0] {S_RUN, S_PAUSED, S_ADJ} state_t;

  state_t     state, state_nxt;
  logic       paused_f, paused_nxt;
  logic       rst_prev, pause_prev;
  logic       rst_edge, pause_edge, sel_sec;
  logic       clr_nxt, sec_nxt, min_nxt;
  logic       phase, phase_nxt;
  logic [3:0] cnt, cnt_nxt;

  always_comb begin
    rst_edge   = btn_rst & ~rst_prev;
    pause_edge = btn_pause & ~pause_prev;
    sel_sec    = (sel == 1'(SEL_SEC_VALUE));
    state_nxt  = state;
    paused_nxt = paused_f;
    clr_nxt    = 1'b0;
    sec_nxt    = 1'b0;
    min_nxt    = 1'b0;
    phase_nxt  = phase;
    cnt_nxt    = cnt;

    // A clear always suppresses the increment of the same cycle.
    if (rst_edge) begin
      clr_nxt    = 1'b1;
      paused_nxt = 1'b0;
      state_nxt  = (state == S_ADJ && adj) ? S_ADJ : S_RUN;
    end else begin
      case (state)
        S_ADJ: begin
          if (!adj) begin
            state_nxt = paused_f ? S_PAUSED : S_RUN;
          end else if (tick_2hz) begin
            sec_nxt = sel_sec;
            min_nxt = ~sel_sec;
          end
        end
        default: begin
          if (adj) begin
            state_nxt = S_ADJ;
          end else if (pause_edge) begin
            paused_nxt = ~paused_f;
            state_nxt  = (state == S_RUN) ? S_PAUSED : S_RUN;
          end else if (state == S_RUN && tick_1hz) begin
            sec_nxt = 1'b1;
            min_nxt = sec_at_max;
          end
        end
      endcase
    end

    // Blink phase only lives while staying in ADJ; any entry or exit restarts it.
    if (state != S_ADJ || state_nxt != S_ADJ) begin
      phase_nxt = 1'b0;
      cnt_nxt   = 4'd0;
    end else if (tick_2hz) begin
      if (cnt + 4'd1 == 4'(BLINK_TICKS)) begin
        phase_nxt = ~phase;
        cnt_nxt   = 4'd0;
      end else begin
        cnt_nxt = cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      paused_f   <= 1'b0;
      rst_prev   <= 1'b1;
      pause_prev <= 1'b1;
      phase      <= 1'b0;
      cnt        <= 4'd0;
      clr        <= 1'b1;
      sec_inc    <= 1'b0;
      min_inc    <= 1'b0;
      running    <= 1'b1;
      adj_mode   <= 1'b0;
      blink_sec  <= 1'b0;
      blink_min  <= 1'b0;
    end else begin
      state      <= state_nxt;
      paused_f   <= paused_nxt;
      rst_prev   <= btn_rst;
      pause_prev <= btn_pause;
      phase      <= phase_nxt;
      cnt        <= cnt_nxt;
      clr        <= clr_nxt;
      sec_inc    <= sec_nxt;
      min_inc    <= min_nxt;
      running    <= (state_nxt == S_RUN);
      adj_mode   <= (state_nxt == S_ADJ);
      blink_sec  <= phase_nxt & sel_sec;
      blink_min  <= phase_nxt & ~sel_sec;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: each step drives one cycle of inputs and
// queues the hand-derived output vector expected after the next clock edge.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst, btn_rst, btn_pause, sel, adj, tick_1hz, tick_2hz, sec_at_max;
  logic clr, sec_inc, min_inc, running, adj_mode, blink_sec, blink_min;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  stopwatch_ctrl #(.BLINK_TICKS(1), .SEL_SEC_VALUE(1)) dut (
    .clk(clk), .rst(rst), .btn_rst(btn_rst), .btn_pause(btn_pause),
    .sel(sel), .adj(adj), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .sec_at_max(sec_at_max), .clr(clr), .sec_inc(sec_inc), .min_inc(min_inc),
    .running(running), .adj_mode(adj_mode), .blink_sec(blink_sec),
    .blink_min(blink_min)
  );

  // Expected vector order: {clr, sec_inc, min_inc, running, adj_mode, blink_sec, blink_min}
  task automatic step(input string tag, input logic r, input logic br,
                      input logic bp, input logic s, input logic a,
                      input logic t1, input logic t2, input logic sm,
                      input logic [6:0] exp);
    logic [6:0] got, want;
    string      t;
    @(negedge clk);
    rst = r; btn_rst = br; btn_pause = bp; sel = s; adj = a;
    tick_1hz = t1; tick_2hz = t2; sec_at_max = sm;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got  = {clr, sec_inc, min_inc, running, adj_mode, blink_sec, blink_min};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    total_cnt++;
    assert (got === want) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", t, got, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; btn_rst = 0; btn_pause = 1; sel = 0; adj = 0;
    tick_1hz = 0; tick_2hz = 0; sec_at_max = 0;

    //     tag                  r  br bp s  a  t1 t2 sm  expected
    step("reset_0",            1, 0, 1, 0, 0, 0, 0, 0, 7'b1001000);
    step("reset_1",            1, 0, 1, 0, 0, 0, 0, 0, 7'b1001000);
    step("pause_held_exit",    0, 0, 1, 0, 0, 0, 0, 0, 7'b0001000);
    step("idle_run",           0, 0, 0, 0, 0, 0, 0, 0, 7'b0001000);
    for (int i = 0; i < 3; i++) begin
      step("run_tick",         0, 0, 0, 0, 0, 1, 0, 0, 7'b0101000);
      step("run_tick_gap",     0, 0, 0, 0, 0, 0, 0, 0, 7'b0001000);
    end
    step("run_carry",          0, 0, 0, 0, 0, 1, 0, 1, 7'b0111000);
    step("max_no_tick",        0, 0, 0, 0, 0, 0, 0, 1, 7'b0001000);

    step("pause_edge",         0, 0, 1, 0, 0, 0, 0, 0, 7'b0000000);
    step("paused_tick_held",   0, 0, 1, 0, 0, 1, 0, 0, 7'b0000000);
    step("paused_tick",        0, 0, 0, 0, 0, 1, 0, 0, 7'b0000000);
    step("resume_edge",        0, 0, 1, 0, 0, 0, 0, 0, 7'b0001000);
    step("resume_tick",        0, 0, 0, 0, 0, 1, 0, 0, 7'b0101000);

    step("pause_again",        0, 0, 1, 0, 0, 0, 0, 0, 7'b0000000);
    step("pause_release",      0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
    step("adj_enter",          0, 0, 0, 1, 1, 0, 0, 0, 7'b0000100);
    step("adj_sec_1",          0, 0, 0, 1, 1, 0, 1, 0, 7'b0100110);
    step("adj_hold_ph1",       0, 0, 0, 1, 1, 0, 0, 0, 7'b0000110);
    step("adj_sec_2",          0, 0, 0, 1, 1, 0, 1, 0, 7'b0100100);
    step("adj_1hz_ignored",    0, 0, 0, 1, 1, 1, 0, 0, 7'b0000100);
    step("adj_sec_3",          0, 0, 0, 1, 1, 0, 1, 0, 7'b0100110);
    step("adj_sec_4",          0, 0, 0, 1, 1, 0, 1, 0, 7'b0100100);
    step("adj_no_carry",       0, 0, 0, 1, 1, 0, 1, 1, 7'b0100110);
    step("adj_sel_flip",       0, 0, 0, 0, 1, 0, 0, 0, 7'b0000101);
    step("adj_min_1",          0, 0, 0, 0, 1, 0, 1, 0, 7'b0010100);
    step("adj_min_2",          0, 0, 0, 0, 1, 0, 1, 0, 7'b0010101);
    step("adj_pause_ignored",  0, 0, 1, 0, 1, 0, 0, 0, 7'b0000101);
    step("adj_pause_release",  0, 0, 0, 0, 1, 0, 0, 0, 7'b0000101);
    step("adj_exit_paused",    0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);

    step("resume_from_pause",  0, 0, 1, 0, 0, 0, 0, 0, 7'b0001000);
    step("resume_release",     0, 0, 0, 0, 0, 0, 0, 0, 7'b0001000);
    step("run_rst_tick",       0, 1, 0, 0, 0, 1, 0, 0, 7'b1001000);
    step("run_rst_release",    0, 0, 0, 0, 0, 0, 0, 0, 7'b0001000);

    step("pause_for_adj",      0, 0, 1, 0, 0, 0, 0, 0, 7'b0000000);
    step("pause_for_adj_rel",  0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
    step("adj_and_pause",      0, 0, 1, 1, 1, 0, 0, 0, 7'b0000100);
    step("adj_after_both",     0, 0, 0, 1, 1, 0, 0, 0, 7'b0000100);
    step("adj_rst_tick",       0, 1, 0, 1, 1, 1, 0, 0, 7'b1000100);
    step("adj_rst_release",    0, 0, 0, 1, 1, 0, 0, 0, 7'b0000100);
    step("adj_exit_run",       0, 0, 0, 1, 0, 0, 0, 0, 7'b0001000);

    step("adj_reenter",        0, 0, 0, 1, 1, 0, 0, 0, 7'b0000100);
    step("adj_phase_up",       0, 0, 0, 1, 1, 0, 1, 0, 7'b0100110);
    step("rst_mid_adj",        1, 0, 0, 1, 1, 0, 1, 0, 7'b1001000);
    step("after_rst_mid_adj",  0, 0, 0, 1, 0, 0, 0, 0, 7'b0001000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
